// File: rtl/hsv_pkg.sv
// ============================================================================
// Module   : hsv_pkg
// Purpose  : Shared types and constants for the HSV mask datapath and its
//            frame controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hsv_pkg;

  localparam int COORD_W     = 13;
  localparam int DEF_MAX_ROW = 477;
  localparam int DEF_MAX_COL = 617;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  typedef struct packed {
    coord_t rmin;
    coord_t rmax;
    coord_t cmin;
    coord_t cmax;
  } bbox_t;

  function automatic coord_t umin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t umax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hsv_bbox_accum.sv
// ============================================================================
// Module   : hsv_bbox_accum
// Purpose  : Per-frame mask pixel counter and bounding-box tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hsv_bbox_accum
  import hsv_pkg::*;
#(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_en,
  input  coord_t           row,
  input  coord_t           col,
  output logic [CNT_W-1:0] count_nxt,
  output bbox_t            bbox_nxt
);

  logic [CNT_W-1:0] count_q, count_d, count_base;
  bbox_t            bbox_q, bbox_d, bbox_base;
  logic             seen_q, seen_d, seen_base;

  // start wipes the previous frame in the same cycle so a pixel arriving
  // alongside it becomes the first pixel of the new frame.
  always_comb begin
    count_base = start ? '0   : count_q;
    bbox_base  = start ? '0   : bbox_q;
    seen_base  = start ? 1'b0 : seen_q;
    count_d    = count_base;
    bbox_d     = bbox_base;
    seen_d     = seen_base;
    if (pix_en) begin
      if (count_base != '1) begin
        count_d = count_base + CNT_W'(1);
      end
      if (!seen_base) begin
        bbox_d = '{rmin: row, rmax: row, cmin: col, cmax: col};
      end else begin
        bbox_d.rmin = umin(bbox_base.rmin, row);
        bbox_d.rmax = umax(bbox_base.rmax, row);
        bbox_d.cmin = umin(bbox_base.cmin, col);
        bbox_d.cmax = umax(bbox_base.cmax, col);
      end
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      bbox_q  <= '0;
      seen_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      bbox_q  <= bbox_d;
      seen_q  <= seen_d;
    end
  end

  assign count_nxt = count_d;
  assign bbox_nxt  = bbox_d;

endmodule

`default_nettype wire

// File: rtl/hsv_mask_frame_ctrl.sv
// ============================================================================
// Module   : hsv_mask_frame_ctrl
// Purpose  : Frame controller: accumulates mask statistics per frame and
//            publishes a report plus a debounced object-present flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hsv_mask_frame_ctrl
  import hsv_pkg::*;
#(
  parameter int MAX_ROW    = DEF_MAX_ROW,
  parameter int MAX_COL    = DEF_MAX_COL,
  parameter int MIN_PIXELS = 256,
  parameter int DEBOUNCE   = 3,
  parameter int CNT_W      = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               mask_bit,
  output logic               busy,
  output logic               report_valid,
  output logic [CNT_W-1:0]   pix_count,
  output logic [COORD_W-1:0] bbox_rmin,
  output logic [COORD_W-1:0] bbox_rmax,
  output logic [COORD_W-1:0] bbox_cmin,
  output logic [COORD_W-1:0] bbox_cmax,
  output logic               obj_present,
  output logic               frame_abort
);

  localparam coord_t      MAX_ROW_C = COORD_W'(MAX_ROW);
  localparam coord_t      MAX_COL_C = COORD_W'(MAX_COL);
  localparam logic [31:0] MIN_PIX_C = 32'(MIN_PIXELS);
  localparam logic [3:0]  DEB_C     = 4'(DEBOUNCE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pix_count_q, pix_count_d;
  bbox_t            bbox_q, bbox_d;
  logic [3:0]       hit_cnt_q, hit_cnt_d;
  logic             obj_q, obj_d;
  logic             report_valid_q, report_valid_d;
  logic             abort_q, abort_d;

  logic             pix_ok;
  logic             acc_start;
  logic             acc_take;
  logic [CNT_W-1:0] acc_count_nxt;
  bbox_t            acc_bbox_nxt;
  logic             frame_hit;

  assign pix_ok    = pix_valid && mask_bit && (row <= MAX_ROW_C) && (col <= MAX_COL_C);
  assign frame_hit = 32'(acc_count_nxt) >= MIN_PIX_C;

  hsv_bbox_accum #(
    .CNT_W (CNT_W)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .start     (acc_start),
    .pix_en    (acc_take),
    .row       (row),
    .col       (col),
    .count_nxt (acc_count_nxt),
    .bbox_nxt  (acc_bbox_nxt)
  );

  always_comb begin
    state_d        = state_q;
    pix_count_d    = pix_count_q;
    bbox_d         = bbox_q;
    hit_cnt_d      = hit_cnt_q;
    obj_d          = obj_q;
    report_valid_d = 1'b0;
    abort_d        = 1'b0;
    acc_start      = 1'b0;
    acc_take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          hit_cnt_d = 4'd0;
          obj_d     = 1'b0;
        end else if (frame_start) begin
          state_d   = ST_ACCUM;
          acc_start = 1'b1;
          acc_take  = pix_ok;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          hit_cnt_d = 4'd0;
          obj_d     = 1'b0;
        end else if (frame_end) begin
          // frame_end beats a coincident frame_start; the start is dropped.
          state_d        = ST_REPORT;
          acc_take       = pix_ok;
          report_valid_d = 1'b1;
          pix_count_d    = acc_count_nxt;
          bbox_d         = acc_bbox_nxt;
          if (frame_hit) begin
            hit_cnt_d = (hit_cnt_q >= DEB_C) ? DEB_C : hit_cnt_q + 4'd1;
          end else begin
            hit_cnt_d = 4'd0;
          end
          obj_d = (hit_cnt_d == DEB_C);
        end else if (frame_start) begin
          abort_d   = 1'b1;
          acc_start = 1'b1;
          acc_take  = pix_ok;
          hit_cnt_d = 4'd0;
          obj_d     = 1'b0;
        end else begin
          acc_take = pix_ok;
        end
      end
      ST_REPORT: begin
        state_d = enable ? ST_ARM : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pix_count_q    <= '0;
      bbox_q         <= '0;
      hit_cnt_q      <= 4'd0;
      obj_q          <= 1'b0;
      report_valid_q <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_count_q    <= pix_count_d;
      bbox_q         <= bbox_d;
      hit_cnt_q      <= hit_cnt_d;
      obj_q          <= obj_d;
      report_valid_q <= report_valid_d;
      abort_q        <= abort_d;
    end
  end

  assign busy         = (state_q == ST_ACCUM);
  assign report_valid = report_valid_q;
  assign pix_count    = pix_count_q;
  assign bbox_rmin    = bbox_q.rmin;
  assign bbox_rmax    = bbox_q.rmax;
  assign bbox_cmin    = bbox_q.cmin;
  assign bbox_cmax    = bbox_q.cmax;
  assign obj_present  = obj_q;
  assign frame_abort  = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_hsv_mask_frame_ctrl.sv
// ============================================================================
// Module   : tb_hsv_mask_frame_ctrl
// Purpose  : Directed self-checking bench for hsv_mask_frame_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hsv_mask_frame_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             frame_start;
  logic             frame_end;
  logic             pix_valid;
  logic [12:0]      row;
  logic [12:0]      col;
  logic             mask_bit;
  logic             busy;
  logic             report_valid;
  logic [CNT_W-1:0] pix_count;
  logic [12:0]      bbox_rmin;
  logic [12:0]      bbox_rmax;
  logic [12:0]      bbox_cmin;
  logic [12:0]      bbox_cmax;
  logic             obj_present;
  logic             frame_abort;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hsv_mask_frame_ctrl #(
    .MAX_ROW    (477),
    .MAX_COL    (617),
    .MIN_PIXELS (4),
    .DEBOUNCE   (3),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .pix_valid    (pix_valid),
    .row          (row),
    .col          (col),
    .mask_bit     (mask_bit),
    .busy         (busy),
    .report_valid (report_valid),
    .pix_count    (pix_count),
    .bbox_rmin    (bbox_rmin),
    .bbox_rmax    (bbox_rmax),
    .bbox_cmin    (bbox_cmin),
    .bbox_cmax    (bbox_cmax),
    .obj_present  (obj_present),
    .frame_abort  (frame_abort)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pix_valid   = 1'b0;
    mask_bit    = 1'b0;
    row         = '0;
    col         = '0;
  endtask

  task automatic set_pix(input int r, input int c);
    pix_valid = 1'b1;
    mask_bit  = 1'b1;
    row       = 13'(r);
    col       = 13'(c);
  endtask

  // n >= 2 mask pixels at (20+i, 30+i); start and end pulses ride on the
  // first and last pixel cycles. Leaves the controller back in ARM.
  task automatic run_frame(input string tag, input int n, input logic [31:0] exp_cnt,
                           input logic exp_obj);
    for (int i = 0; i < n; i++) begin
      clear_in();
      frame_start = (i == 0);
      frame_end   = (i == n - 1);
      set_pix(20 + i, 30 + i);
      step();
    end
    clear_in();
    check({tag, "_rv"}, 32'(report_valid), 32'd1);
    check({tag, "_cnt"}, 32'(pix_count), exp_cnt);
    check({tag, "_obj"}, 32'(obj_present), 32'(exp_obj));
    step();
    check({tag, "_rv_off"}, 32'(report_valid), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    clear_in();
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(report_valid), 32'd0);
    check("rst_cnt", 32'(pix_count), 32'd0);
    check("rst_obj", 32'(obj_present), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    step();

    // frame_end while armed is ignored
    frame_end = 1'b1;
    step();
    clear_in();
    check("arm_end_rv", 32'(report_valid), 32'd0);

    // basic bbox frame
    frame_start = 1'b1;
    step();
    clear_in();
    check("t1_busy", 32'(busy), 32'd1);
    set_pix(10, 20);  step();
    set_pix(100, 5);  step();
    set_pix(50, 300); step();
    clear_in();
    frame_end = 1'b1;
    step();
    clear_in();
    check("t1_rv", 32'(report_valid), 32'd1);
    check("t1_cnt", 32'(pix_count), 32'd3);
    check("t1_rmin", 32'(bbox_rmin), 32'd10);
    check("t1_rmax", 32'(bbox_rmax), 32'd100);
    check("t1_cmin", 32'(bbox_cmin), 32'd5);
    check("t1_cmax", 32'(bbox_cmax), 32'd300);
    step();
    check("t1_rv_off", 32'(report_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // out-of-range and unqualified pixels only
    frame_start = 1'b1;
    step();
    clear_in();
    set_pix(478, 10); step();
    set_pix(10, 618); step();
    set_pix(30, 30); mask_bit = 1'b0; step();
    set_pix(40, 40); pix_valid = 1'b0; step();
    clear_in();
    frame_end = 1'b1;
    step();
    clear_in();
    check("t2_rv", 32'(report_valid), 32'd1);
    check("t2_cnt", 32'(pix_count), 32'd0);
    check("t2_rmin", 32'(bbox_rmin), 32'd0);
    check("t2_rmax", 32'(bbox_rmax), 32'd0);
    check("t2_cmin", 32'(bbox_cmin), 32'd0);
    check("t2_cmax", 32'(bbox_cmax), 32'd0);
    check("t2_obj", 32'(obj_present), 32'd0);
    step();

    // debounce
    run_frame("t3a", 5, 32'd5, 1'b0);
    run_frame("t3b", 5, 32'd5, 1'b0);
    run_frame("t3c", 5, 32'd5, 1'b1);
    run_frame("t3d", 2, 32'd2, 1'b0);

    // abort on missing frame_end
    run_frame("t4a", 5, 32'd5, 1'b0);
    run_frame("t4b", 5, 32'd5, 1'b0);
    frame_start = 1'b1;
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      set_pix(1, 1);
      step();
    end
    clear_in();
    frame_start = 1'b1;
    set_pix(5, 5);
    step();
    clear_in();
    check("t4_abort", 32'(frame_abort), 32'd1);
    check("t4_abort_busy", 32'(busy), 32'd1);
    check("t4_abort_rv", 32'(report_valid), 32'd0);
    check("t4_abort_obj", 32'(obj_present), 32'd0);
    for (int i = 6; i < 9; i++) begin
      set_pix(i, i);
      step();
      if (i == 6) check("t4_abort_off", 32'(frame_abort), 32'd0);
    end
    clear_in();
    frame_end = 1'b1;
    set_pix(9, 9);
    step();
    clear_in();
    check("t4_rv", 32'(report_valid), 32'd1);
    check("t4_cnt", 32'(pix_count), 32'd5);
    check("t4_rmin", 32'(bbox_rmin), 32'd5);
    check("t4_rmax", 32'(bbox_rmax), 32'd9);
    check("t4_obj", 32'(obj_present), 32'd0);
    step();
    run_frame("t4c", 5, 32'd5, 1'b0);
    run_frame("t4d", 5, 32'd5, 1'b1);

    // asynchronous reset mid-frame
    frame_start = 1'b1;
    step();
    clear_in();
    for (int i = 0; i < 10; i++) begin
      set_pix(3, 3);
      step();
    end
    clear_in();
    #2 rst = 1'b1;
    #1;
    check("t5_async_cnt", 32'(pix_count), 32'd0);
    check("t5_async_obj", 32'(obj_present), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_rmax", 32'(bbox_rmax), 32'd0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    run_frame("t5", 3, 32'd3, 1'b0);
    check("t5_rmin", 32'(bbox_rmin), 32'd20);
    check("t5_cmax", 32'(bbox_cmax), 32'd32);

    // saturation, then coincident start/end
    run_frame("t6a", 21, 32'd15, 1'b0);
    check("t6_rmax", 32'(bbox_rmax), 32'd40);
    check("t6_cmin", 32'(bbox_cmin), 32'd30);
    frame_start = 1'b1;
    set_pix(7, 7);
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      set_pix(8, 8);
      step();
    end
    clear_in();
    frame_start = 1'b1;
    frame_end   = 1'b1;
    set_pix(9, 9);
    step();
    clear_in();
    check("t6_rv", 32'(report_valid), 32'd1);
    check("t6_cnt", 32'(pix_count), 32'd5);
    check("t6_abort", 32'(frame_abort), 32'd0);
    check("t6_obj", 32'(obj_present), 32'd0);
    step();
    check("t6_busy_rep", 32'(busy), 32'd0);
    step();
    check("t6_busy_arm", 32'(busy), 32'd0);
    frame_start = 1'b1;
    step();
    clear_in();
    check("t6_rearm", 32'(busy), 32'd1);

    // enable drop discards the frame and holds last report
    enable = 1'b0;
    step();
    check("en_busy", 32'(busy), 32'd0);
    step();
    check("en_rv", 32'(report_valid), 32'd0);
    check("en_hold_cnt", 32'(pix_count), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/hsv_mask_frame_ctrl.md
Name: hsv_mask_frame_ctrl

Overview:
- Frame-level controller behind the per-pixel HSV colour-mask datapath.
- Arms on a frame boundary and accumulates the mask bit over the valid region: pixel count and bounding box.
- At frame end it publishes a one-cycle report and updates a debounced object-present flag.
- Downstream overlay and tracking logic read the report instead of the raw per-pixel mask.

Parameters:
- MAX_ROW, 477, last valid row; pixels with row > MAX_ROW are ignored.
- MAX_COL, 617, last valid col; pixels with col > MAX_COL are ignored.
- MIN_PIXELS, 256, minimum mask count for a frame to be a "hit".
- DEBOUNCE, 3, consecutive hit frames needed to assert obj_present (range 1..15).
- CNT_W, 19, pixel-counter width; saturates at all-ones.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  controller run enable.
- frame_start  in  1  single-cycle pulse at first pixel slot of a frame.
- frame_end  in  1  single-cycle pulse on the last pixel slot of a frame.
- pix_valid  in  1  row/col/mask_bit valid this cycle.
- row  in  13  current pixel row.
- col  in  13  current pixel column.
- mask_bit  in  1  colour-match bit from the HSV mask datapath.
- busy  out  1  high in ACCUM.
- report_valid  out  1  one-cycle pulse; report fields are valid.
- pix_count  out  CNT_W  mask pixels in the last completed frame.
- bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax  out  13 each  bounding box of mask pixels in the last completed frame.
- obj_present  out  1  debounced detection flag.
- frame_abort  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; accumulators cleared; hit counter 0.
- States:
  - IDLE: enable=1 -> ARM.
  - ARM: frame_start -> ACCUM. Accumulators are cleared on entry to ACCUM; a pixel on the frame_start cycle is counted.
  - ACCUM: frame_end -> REPORT.
  - REPORT: one cycle, then ARM (or IDLE if enable=0).
- enable=0 in ARM or ACCUM -> IDLE next cycle; partial frame discarded; no report; obj_present and hit counter cleared; last report fields held.
- Qualified pixel: pix_valid and mask_bit and row<=MAX_ROW and col<=MAX_COL, in ACCUM (or on the ARM->ACCUM or ACCUM->REPORT edge cycle).
  - Count increments by 1 and saturates at 2^CNT_W-1.
  - The first qualified pixel loads rmin=rmax=row and cmin=cmax=col.
  - Later pixels take min/max per axis. Use unsigned compares only.
- Latency: frame_end sampled at cycle t -> report_valid=1 at t+1.
  - pix_count and bbox registered at t+1, including any qualified pixel at cycle t.
  - obj_present updates at t+1.
- Zero-pixel frame: pix_count=0, all bbox fields=0.
- Debounce:
  - hit = final count >= MIN_PIXELS.
  - On hit, the hit counter increments, saturating at DEBOUNCE. On miss, the counter is set to 0.
  - obj_present = (counter == DEBOUNCE) after the update.
- frame_start while in ACCUM (missing frame_end):
  - frame_abort pulses next cycle; hit counter cleared; obj_present cleared.
  - Accumulators restart with this frame; no report for the dropped frame.
- frame_start and frame_end in the same cycle in ACCUM: frame_end wins. Report as normal, go to ARM; this frame_start is ignored.
- frame_end in ARM or IDLE: ignored.
- Outputs other than the pulses hold between reports.

Decomposition:
- Shared package (e.g. hsv_pkg) holds:
  - the state enum (IDLE, ARM, ACCUM, REPORT);
  - the 13-bit coordinate width;
  - default MAX_ROW/MAX_COL constants, shared with the mask datapath.
- One natural sub-module: hsv_bbox_accum, holding count, min/max registers and the first-pixel flag, with clear/update/saturate.
- FSM and debounce stay in the top.

Test Plan:
1. enable=1, start; mask pixels at (10,20), (100,5), (50,300); end -> report_valid one cycle after end, pix_count=3, rmin=10, rmax=100, cmin=5, cmax=300.
2. Mask pixels at (478,10) and (10,618), nothing else; end -> pix_count=0, bbox all 0, obj_present=0.
3. MIN_PIXELS=4, DEBOUNCE=3; frames with counts 5,5,5,2 -> obj_present 0,0,1,0 after each report.
4. Two hit frames, then frame_start mid-ACCUM without frame_end -> frame_abort pulse; obj_present stays 0 even if the next frame hits; three further hits -> 1.
5. rst asserted mid-ACCUM with count 40 -> all outputs 0 immediately (asynchronously); next frame after rst release reports only its own pixels.
6. Force 2^CNT_W+5 mask pixels (CNT_W reduced to 4) -> pix_count=15; frame_start and frame_end coincident -> report issued, controller returns to ARM.
